// File: rtl/peak_pkg.sv
// Shared types and default widths for the peak/trough interval detector.
package peak_pkg;

    localparam int unsigned DEF_W    = 10;
    localparam int unsigned DEF_HYST = 8;

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        SEEK_PEAK,
        SEEK_TROUGH
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clr has priority over inc.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         sat_c
);

    assign sat_c = &count;

    // Count register: clear, else increment until saturated.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !sat_c) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/peak_interval_detector.sv
// Hysteresis peak/trough detector with refractory window and peak-to-peak interval.
module peak_interval_detector
    import peak_pkg::*;
#(
    parameter int unsigned W       = DEF_W,
    parameter int unsigned HYST    = DEF_HYST,
    parameter int unsigned CNT_W   = 10,
    parameter int unsigned INT_W   = 16,
    parameter int unsigned REFRACT = 50
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_valid,
    input  logic [W-1:0]     sample,
    input  logic             clear,
    output logic             peak_pulse,
    output logic             trough_pulse,
    output logic [CNT_W-1:0] num_peaks,
    output logic [CNT_W-1:0] num_troughs,
    output logic [INT_W-1:0] interval,
    output logic             interval_valid,
    output logic             overflow
);

    // One extra bit so that x + HYST never wraps.
    localparam int unsigned CW = W + 1;
    localparam logic [INT_W-1:0] INT_MAX = '1;

    state_t           state, state_nx;
    logic [W-1:0]     lo, hi, ext;
    logic [W-1:0]     lo_nx, hi_nx, ext_nx;
    logic [CW-1:0]    s_x, lo_x, hi_x, ext_x, hyst_x;
    logic [INT_W-1:0] since_peak, d;
    logic             since_sat;
    logic             first_peak;
    logic             peak_conf, trough_conf, accept, emit_interval;

    assign s_x    = {1'b0, sample};
    assign lo_x   = {1'b0, lo};
    assign hi_x   = {1'b0, hi};
    assign ext_x  = {1'b0, ext};
    assign hyst_x = CW'(HYST);

    // Distance to the previous accepted peak if this sample confirms one.
    assign d = since_sat ? since_peak : since_peak + INT_W'(1);

    // Samples since the last accepted peak; restarts on acceptance or clear.
    sat_counter #(.W(INT_W)) u_since_peak (
        .clk   (clk),
        .reset (reset),
        .clr   (clear | accept),
        .inc   (sample_valid),
        .count (since_peak),
        .sat_c (since_sat)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else if (clear) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state, extremum tracking and peak/trough confirmation.
    always_comb begin
        state_nx      = state;
        lo_nx         = lo;
        hi_nx         = hi;
        ext_nx        = ext;
        peak_conf     = 1'b0;
        trough_conf   = 1'b0;
        accept        = 1'b0;
        emit_interval = 1'b0;
        if (sample_valid && !clear) begin
            case (state)
                IDLE: begin
                    lo_nx    = sample;
                    hi_nx    = sample;
                    state_nx = TRACK;
                end
                TRACK: begin
                    if (sample < lo) lo_nx = sample;
                    if (sample > hi) hi_nx = sample;
                    if (s_x >= lo_x + hyst_x) begin
                        state_nx = SEEK_PEAK;
                        ext_nx   = sample;
                    end else if (s_x + hyst_x <= hi_x) begin
                        state_nx = SEEK_TROUGH;
                        ext_nx   = sample;
                    end
                end
                SEEK_PEAK: begin
                    if (sample > ext) begin
                        ext_nx = sample;
                    end else if (s_x + hyst_x <= ext_x) begin
                        peak_conf = 1'b1;
                        state_nx  = SEEK_TROUGH;
                        ext_nx    = sample;
                    end
                end
                SEEK_TROUGH: begin
                    if (sample < ext) begin
                        ext_nx = sample;
                    end else if (s_x >= ext_x + hyst_x) begin
                        trough_conf = 1'b1;
                        state_nx    = SEEK_PEAK;
                        ext_nx      = sample;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
        accept        = peak_conf && (first_peak || (32'(d) >= REFRACT));
        emit_interval = accept && !first_peak;
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lo             <= '0;
            hi             <= '0;
            ext            <= '0;
            first_peak     <= 1'b1;
            peak_pulse     <= 1'b0;
            trough_pulse   <= 1'b0;
            num_peaks      <= '0;
            num_troughs    <= '0;
            interval       <= '0;
            interval_valid <= 1'b0;
            overflow       <= 1'b0;
        end else if (clear) begin
            lo             <= '0;
            hi             <= '0;
            ext            <= '0;
            first_peak     <= 1'b1;
            peak_pulse     <= 1'b0;
            trough_pulse   <= 1'b0;
            num_peaks      <= '0;
            num_troughs    <= '0;
            interval       <= '0;
            interval_valid <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            lo             <= lo_nx;
            hi             <= hi_nx;
            ext            <= ext_nx;
            peak_pulse     <= accept;
            trough_pulse   <= trough_conf;
            interval_valid <= emit_interval;
            if (accept) begin
                first_peak <= 1'b0;
                num_peaks  <= num_peaks + CNT_W'(1);
            end
            if (trough_conf) begin
                num_troughs <= num_troughs + CNT_W'(1);
            end
            if (emit_interval) begin
                interval <= d;
                if (d == INT_MAX) overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_peak_interval_detector.sv
// Directed scoreboard bench for peak_interval_detector.
module tb_peak_interval_detector;
    import peak_pkg::*;

    localparam int K_NONE   = 0;
    localparam int K_PEAK   = 1;
    localparam int K_PEAKI  = 2;
    localparam int K_TROUGH = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       sample_valid;
    logic [9:0] sample;
    logic       clear;

    logic        peak_pulse, trough_pulse, interval_valid, overflow;
    logic [9:0]  num_peaks, num_troughs;
    logic [15:0] interval;

    logic        s_peak_pulse, s_trough_pulse, s_interval_valid, s_overflow;
    logic [9:0]  s_num_peaks, s_num_troughs;
    logic [3:0]  s_interval;

    typedef struct {
        logic pk;
        logic tr;
        logic iv;
        int   ivl;
        int   np;
        int   nt;
    } ev_t;

    ev_t q[$];
    ev_t mon_e;
    int  n_checks = 0;
    int  n_pass   = 0;
    int  exp_peaks = 0;
    int  exp_troughs = 0;

    int r_s [22] = '{0, 10, 20, 30, 40, 50, 60, 70, 80, 90, 100,
                     90, 80, 90, 82, 70, 60, 70, 80, 90, 100, 90};
    int r_k [22] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                     K_PEAK, 0, K_TROUGH, 0, 0, 0, K_TROUGH, 0, 0, 0, K_PEAKI};

    always #5 clk = ~clk;

    peak_interval_detector #(
        .W(10), .HYST(8), .CNT_W(10), .INT_W(16), .REFRACT(4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .sample_valid   (sample_valid),
        .sample         (sample),
        .clear          (clear),
        .peak_pulse     (peak_pulse),
        .trough_pulse   (trough_pulse),
        .num_peaks      (num_peaks),
        .num_troughs    (num_troughs),
        .interval       (interval),
        .interval_valid (interval_valid),
        .overflow       (overflow)
    );

    peak_interval_detector #(
        .W(10), .HYST(8), .CNT_W(10), .INT_W(4), .REFRACT(4)
    ) dut_s (
        .clk            (clk),
        .reset          (reset),
        .sample_valid   (sample_valid),
        .sample         (sample),
        .clear          (clear),
        .peak_pulse     (s_peak_pulse),
        .trough_pulse   (s_trough_pulse),
        .num_peaks      (s_num_peaks),
        .num_troughs    (s_num_troughs),
        .interval       (s_interval),
        .interval_valid (s_interval_valid),
        .overflow       (s_overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic logic [9:0] tri_v(input int k);
        int p;
        p = k % 20;
        return (p <= 10) ? 10'(10 * p) : 10'(200 - 10 * p);
    endfunction

    function automatic int tri_kind(input int k);
        if (k == 11) return K_PEAK;
        if (k % 20 == 11) return K_PEAKI;
        if (k >= 21 && k % 20 == 1) return K_TROUGH;
        return K_NONE;
    endfunction

    // Drive one cycle; queue the event this sample is expected to produce.
    task automatic step(input logic [9:0] s, input logic v, input int kind, input int ivl);
        ev_t e;
        sample       = s;
        sample_valid = v;
        if (kind != K_NONE) begin
            if (kind == K_TROUGH) exp_troughs++;
            else exp_peaks++;
            e.pk  = (kind != K_TROUGH);
            e.tr  = (kind == K_TROUGH);
            e.iv  = (kind == K_PEAKI);
            e.ivl = ivl;
            e.np  = exp_peaks;
            e.nt  = exp_troughs;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        @(negedge clk);
        #1;
        if (kind != K_NONE) check("event_latency", 32'(q.size()), 32'd0);
    endtask

    task automatic do_clear(input logic [9:0] s);
        sample       = s;
        sample_valid = 1'b1;
        clear        = 1'b1;
        @(posedge clk);
        #1;
        clear        = 1'b0;
        sample_valid = 1'b0;
        exp_peaks    = 0;
        exp_troughs  = 0;
        q.delete();
        @(negedge clk);
        #1;
    endtask

    // Scoreboard: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && (peak_pulse || trough_pulse || interval_valid)) begin
            if (q.size() == 0) begin
                check("spurious_pulse", 32'({peak_pulse, trough_pulse, interval_valid}), 32'd0);
            end else begin
                mon_e = q.pop_front();
                check("peak_pulse", 32'(peak_pulse), 32'(mon_e.pk));
                check("trough_pulse", 32'(trough_pulse), 32'(mon_e.tr));
                check("interval_valid", 32'(interval_valid), 32'(mon_e.iv));
                check("num_peaks_ev", 32'(num_peaks), 32'(mon_e.np));
                check("num_troughs_ev", 32'(num_troughs), 32'(mon_e.nt));
                if (mon_e.iv) check("interval_ev", 32'(interval), 32'(mon_e.ivl));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        reset        = 1'b1;
        clear        = 1'b0;
        sample_valid = 1'b0;
        sample       = '0;
        #12;
        check("rst_num_peaks", 32'(num_peaks), 32'd0);
        check("rst_num_troughs", 32'(num_troughs), 32'd0);
        check("rst_interval", 32'(interval), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_pulses", 32'({peak_pulse, trough_pulse, interval_valid}), 32'd0);
        check("rst_state", 32'(dut.state), 32'(IDLE));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Triangle stream; also drives the narrow-interval instance into saturation.
        for (int k = 0; k < 52; k++) begin
            step(tri_v(k), 1'b1, tri_kind(k), 20);
            if (k == 31) begin
                check("sat_interval", 32'(s_interval), 32'd15);
                check("sat_overflow", 32'(s_overflow), 32'd1);
            end
        end
        step(10'd80, 1'b1, K_NONE, 0);
        step(10'd90, 1'b1, K_TROUGH, 0);
        step(10'd100, 1'b1, K_NONE, 0);
        step(10'd90, 1'b1, K_PEAKI, 4);
        check("tri_num_peaks", 32'(num_peaks), 32'd4);
        check("tri_num_troughs", 32'(num_troughs), 32'd3);
        check("tri_interval", 32'(interval), 32'd4);
        check("tri_overflow", 32'(overflow), 32'd0);
        check("sat_interval_inrange", 32'(s_interval), 32'd4);
        check("sat_overflow_sticky", 32'(s_overflow), 32'd1);
        check("sat_num_peaks", 32'(s_num_peaks), 32'd4);

        // Clear while seeking a peak; the accompanying sample must be dropped.
        step(10'd80, 1'b1, K_NONE, 0);
        step(10'd90, 1'b1, K_TROUGH, 0);
        check("pre_clear_state", 32'(dut.state), 32'(SEEK_PEAK));
        do_clear(10'd100);
        check("clr_num_peaks", 32'(num_peaks), 32'd0);
        check("clr_num_troughs", 32'(num_troughs), 32'd0);
        check("clr_interval", 32'(interval), 32'd0);
        check("clr_overflow", 32'(s_overflow), 32'd0);
        check("clr_state", 32'(dut.state), 32'(IDLE));
        step(10'd50, 1'b1, K_NONE, 0);
        step(10'd60, 1'b1, K_NONE, 0);
        check("clr_dropped_state", 32'(dut.state), 32'(SEEK_PEAK));

        // Noise below hysteresis never leaves TRACK.
        do_clear(10'd0);
        for (int i = 0; i < 100; i++) step((i % 2) ? 10'd55 : 10'd50, 1'b1, K_NONE, 0);
        check("noise_num_peaks", 32'(num_peaks), 32'd0);
        check("noise_num_troughs", 32'(num_troughs), 32'd0);
        check("noise_state", 32'(dut.state), 32'(TRACK));

        // Refractory rejection of a peak three samples after the first.
        do_clear(10'd0);
        for (int i = 0; i < 22; i++) begin
            step(10'(r_s[i]), 1'b1, r_k[i], 10);
            if (i == 14) check("refract_reject", 32'(num_peaks), 32'd1);
        end
        check("refract_num_peaks", 32'(num_peaks), 32'd2);
        check("refract_num_troughs", 32'(num_troughs), 32'd2);
        check("refract_interval", 32'(interval), 32'd10);

        // Triangle with random idle gaps: results identical to the dense stream.
        do_clear(10'd0);
        for (int k = 0; k < 52; k++) begin
            int gaps;
            gaps = int'($urandom_range(0, 2));
            for (int g = 0; g < gaps; g++) step(10'($urandom_range(0, 1023)), 1'b0, K_NONE, 0);
            step(tri_v(k), 1'b1, tri_kind(k), 20);
        end
        check("gap_num_peaks", 32'(num_peaks), 32'd3);
        check("gap_num_troughs", 32'(num_troughs), 32'd2);
        check("gap_interval", 32'(interval), 32'd20);
        check("gap_overflow", 32'(overflow), 32'd0);

        // Asynchronous reset mid-stream takes effect before the next edge.
        step(10'd80, 1'b1, K_NONE, 0);
        check("pre_reset_peaks", 32'(num_peaks), 32'd3);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_num_peaks", 32'(num_peaks), 32'd0);
        check("async_num_troughs", 32'(num_troughs), 32'd0);
        check("async_interval", 32'(interval), 32'd0);
        check("async_state", 32'(dut.state), 32'(IDLE));
        check("async_sat_peaks", 32'(s_num_peaks), 32'd0);
        q.delete();
        #1;
        reset = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
